operand_stage: RTL

Operand-fetch stage directly upstream of the ALU. It holds the 32x32 register file, decodes register and immediate fields from the instruction word, and extends the immediate. It registers the ALU operands `A`, `B` and `Op` into a single pipeline slot with a valid/ready handshake. Writeback from later stages enters through a dedicated write port, with same-cycle bypass into the operand read.

---
 rtl/operand_stage_if.sv | 31 +++
 rtl/operand_stage.sv | 102 ++++++++++
 2 files changed

// File: rtl/operand_stage_if.sv
// Bundle for the operand stage: the instruction/handshake input side, the writeback
// port and the registered ALU operand slot.
interface operand_stage_if #(
  parameter int ADDR_W = 5
);
  logic              In_Valid;
  logic              In_Ready;
  logic [31:0]       Instr;
  logic [1:0]        ImmExt;
  logic              ALUSrc;
  logic [3:0]        ALUFunc;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [31:0]       Wr_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [31:0]       A;
  logic [31:0]       B;
  logic [3:0]        Op;
  logic [4:0]        Rd_Addr;

  modport master (
    output In_Valid, Instr, ImmExt, ALUSrc, ALUFunc, Wr_En, Wr_Addr, Wr_Data, Out_Ready,
    input  In_Ready, Out_Valid, A, B, Op, Rd_Addr
  );

  modport slave (
    input  In_Valid, Instr, ImmExt, ALUSrc, ALUFunc, Wr_En, Wr_Addr, Wr_Data, Out_Ready,
    output In_Ready, Out_Valid, A, B, Op, Rd_Addr
  );
endinterface

// File: rtl/operand_stage.sv
// Operand-fetch stage: register file with writeback bypass, immediate extension and
// a single registered valid/ready slot holding A, B, Op and the destination register.
module operand_stage #(
  parameter int ADDR_W = 5
) (
  input  logic Clk,
  input  logic Reset,
  operand_stage_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [31:0] rf_q [NREG];

  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_ext, rs_val, rt_val;
  logic        accept;

  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;

  logic unused_opcode;
  assign unused_opcode = ^bus.Instr[31:26];

  assign rs  = bus.Instr[25:21];
  assign rt  = bus.Instr[20:16];
  assign rd  = bus.Instr[15:11];
  assign imm = bus.Instr[15:0];

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.Wr_En && bus.Wr_Addr != '0) begin
      rf_q[bus.Wr_Addr] <= bus.Wr_Data;
    end
  end

  // A writeback landing on this edge must be seen by an operand captured on it.
  always_comb begin
    rs_val = rf_q[rs];
    if (rs == '0)                              rs_val = '0;
    else if (bus.Wr_En && bus.Wr_Addr == rs)   rs_val = bus.Wr_Data;
    rt_val = rf_q[rt];
    if (rt == '0)                              rt_val = '0;
    else if (bus.Wr_En && bus.Wr_Addr == rt)   rt_val = bus.Wr_Data;
  end

  always_comb begin
    imm_ext = '0;
    case (bus.ImmExt)
      2'b00:   imm_ext = {{16{imm[15]}}, imm};
      2'b01:   imm_ext = {16'h0000, imm};
      2'b10:   imm_ext = {imm, 16'h0000};
      default: imm_ext = {{14{imm[15]}}, imm, 2'b00};
    endcase
  end

  assign bus.In_Ready = !valid_q || bus.Out_Ready;
  assign accept       = bus.In_Valid && bus.In_Ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = rs_val;
      b_d     = bus.ALUSrc ? imm_ext : rt_val;
      op_d    = bus.ALUFunc;
      rd_d    = bus.ALUSrc ? rt : rd;
    end else if (bus.Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.Out_Valid = valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.Op        = op_q;
  assign bus.Rd_Addr   = rd_q;
endmodule
